frame_capture_ctrl: RTL and testbench

Sequences capture of recovered camera pixels (pixel, data-valid and hcount/vcount from the pixel recovery stage) into a double-buffered frame BRAM. Aligns capture to frame boundaries and generates BRAM write enable, address and data. Arbitrates ownership of the two buffers between the camera writer and one downstream reader (display or lightboard processing). Swaps buffers only on a complete frame that the reader has released. Sits between pixel recovery and the frame buffer BRAM on the 65 MHz system clock.

---
 rtl/frame_capture_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_frame_capture_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_capture_ctrl.sv
// rtl/frame_capture_ctrl.sv - double-buffered camera frame capture sequencer
//
// Purpose:
//   Aligns capture of recovered camera pixels to frame boundaries, drives
//   the frame BRAM write port and hands complete frames to one downstream
//   reader by swapping ownership of two buffers. A swap happens only when a
//   whole frame was written and the reader has released its buffer.
//
// Optional feature (compile-time macro CAPTURE_TIMEOUT_EN):
//   Adds a watchdog that returns to IDLE if ARMED/CAPTURE sees no
//   frame_done_in for TIMEOUT_CYCLES clocks. Undefined: timeout_out is 0.
//
// Ports:
//   system_clk_in      in   1       65 MHz system clock (only clock)
//   rst_n_in           in   1       asynchronous active-low reset
//   arm_in             in   1       pulse, single-shot capture request
//   continuous_in      in   1       level, capture every frame while high
//   frame_done_in      in   1       pulse, frame boundary
//   data_valid_in      in   1       pulse, pixel/hcount/vcount valid
//   pixel_in           in   16      RGB565 pixel
//   hcount_in          in   11      pixel column
//   vcount_in          in   10      pixel line
//   reader_release_in  in   1       pulse, reader done with its buffer
//   wr_en_out          out  1       BRAM write enable
//   wr_addr_out        out  ADDR_W  BRAM write address in writer buffer
//   wr_data_out        out  16      BRAM write data
//   wr_buf_sel_out     out  1       buffer owned by the writer
//   rd_buf_sel_out     out  1       buffer owned by the reader
//   frame_ready_out    out  1       pulse on a buffer swap
//   busy_out           out  1       high in ARMED or CAPTURE
//   overrun_out        out  1       pulse, complete frame dropped
//   short_frame_out    out  1       pulse, frame ended incomplete
//   timeout_out        out  1       pulse, watchdog expired

module frame_capture_ctrl #(
  parameter int H_ACTIVE       = 320,
  parameter int V_ACTIVE       = 240,
  parameter int ADDR_W         = 17,
  parameter int TIMEOUT_CYCLES = 4000000
) (
  input  logic              system_clk_in,
  input  logic              rst_n_in,
  input  logic              arm_in,
  input  logic              continuous_in,
  input  logic              frame_done_in,
  input  logic              data_valid_in,
  input  logic [15:0]       pixel_in,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  input  logic              reader_release_in,
  output logic              wr_en_out,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic [15:0]       wr_data_out,
  output logic              wr_buf_sel_out,
  output logic              rd_buf_sel_out,
  output logic              frame_ready_out,
  output logic              busy_out,
  output logic              overrun_out,
  output logic              short_frame_out,
  output logic              timeout_out
);

  localparam int               TOTAL     = H_ACTIVE * V_ACTIVE;
  localparam int               CNT_W     = $clog2(TOTAL + 1);
  localparam logic [CNT_W-1:0] TOTAL_CNT = CNT_W'(TOTAL);
  localparam logic [10:0]      H_LIM     = 11'(H_ACTIVE);
  localparam logic [9:0]       V_LIM     = 10'(V_ACTIVE);

  // Catch a buffer too small for one frame, or a meaningless watchdog limit.
  if (((64'd1 << ADDR_W) < 64'(TOTAL)) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
    $error("frame_capture_ctrl: invalid parameter set");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic               rd_free_q, rd_free_d;
  logic               wr_buf_sel_d;
  logic               wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_d;
  logic [15:0]        wr_data_d;
  logic               frame_ready_d;
  logic               overrun_d;
  logic               short_frame_d;
  logic               timeout_d;
  logic               pix_ok;
  logic               wd_expired;

`ifdef CAPTURE_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

  // Fires in the cycle the counter would reach TIMEOUT_CYCLES. A frame
  // boundary in the same cycle takes precedence because it clears the count.
  assign wd_expired = (state_q != ST_IDLE) && !frame_done_in &&
                      (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wd_cnt_d = '0;
    if (state_q != ST_IDLE && !frame_done_in && !wd_expired) begin
      wd_cnt_d = wd_cnt_q + WD_W'(1);
    end
  end

  // IDLE holds the counter at zero, so entry to ARMED always starts fresh.
  always_ff @(posedge system_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end
`else
  assign wd_expired = 1'b0;
`endif

  assign pix_ok = data_valid_in && !frame_done_in &&
                  (hcount_in < H_LIM) && (vcount_in < V_LIM);

  always_comb begin
    state_d       = state_q;
    pix_cnt_d     = pix_cnt_q;
    // A release is sticky and is honoured in every state.
    rd_free_d     = rd_free_q | reader_release_in;
    wr_buf_sel_d  = wr_buf_sel_out;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_out;
    wr_data_d     = wr_data_out;
    frame_ready_d = 1'b0;
    overrun_d     = 1'b0;
    short_frame_d = 1'b0;
    timeout_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arm_in || continuous_in) begin
          state_d = ST_ARMED;
        end
      end

      ST_ARMED: begin
        // Start only at a boundary so a partial frame is never captured.
        if (frame_done_in) begin
          pix_cnt_d = '0;
          state_d   = ST_CAPTURE;
        end else if (wd_expired) begin
          timeout_d = 1'b1;
          pix_cnt_d = '0;
          state_d   = ST_IDLE;
        end
      end

      ST_CAPTURE: begin
        if (frame_done_in) begin
          if (pix_cnt_q == TOTAL_CNT) begin
            if (rd_free_q) begin
              wr_buf_sel_d  = ~wr_buf_sel_out;
              frame_ready_d = 1'b1;
              // A release in the swap cycle belongs to the new reader buffer.
              rd_free_d     = reader_release_in;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            short_frame_d = 1'b1;
          end
          pix_cnt_d = '0;
          state_d   = continuous_in ? ST_CAPTURE : ST_IDLE;
        end else if (wd_expired) begin
          timeout_d = 1'b1;
          pix_cnt_d = '0;
          state_d   = ST_IDLE;
        end else if (pix_ok) begin
          wr_en_d   = 1'b1;
          wr_addr_d = ADDR_W'(32'(vcount_in) * 32'(H_ACTIVE) + 32'(hcount_in));
          wr_data_d = pixel_in;
          if (pix_cnt_q != TOTAL_CNT) begin
            pix_cnt_d = pix_cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge system_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q         <= ST_IDLE;
      pix_cnt_q       <= '0;
      rd_free_q       <= 1'b1;
      wr_buf_sel_out  <= 1'b0;
      wr_en_out       <= 1'b0;
      wr_addr_out     <= '0;
      wr_data_out     <= '0;
      frame_ready_out <= 1'b0;
      overrun_out     <= 1'b0;
      short_frame_out <= 1'b0;
      timeout_out     <= 1'b0;
    end else begin
      state_q         <= state_d;
      pix_cnt_q       <= pix_cnt_d;
      rd_free_q       <= rd_free_d;
      wr_buf_sel_out  <= wr_buf_sel_d;
      wr_en_out       <= wr_en_d;
      wr_addr_out     <= wr_addr_d;
      wr_data_out     <= wr_data_d;
      frame_ready_out <= frame_ready_d;
      overrun_out     <= overrun_d;
      short_frame_out <= short_frame_d;
      timeout_out     <= timeout_d;
    end
  end

  assign rd_buf_sel_out = ~wr_buf_sel_out;
  assign busy_out       = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// tb/tb_frame_capture_ctrl.sv - directed self-checking bench for frame_capture_ctrl
//
// Uses a 320x3 frame (960 pixels) so several full frames fit in a short run
// while keeping the 320-pixel line, so addr(h=5,v=2) is still 645.

module tb_frame_capture_ctrl;

  localparam int H  = 320;
  localparam int V  = 3;
  localparam int FR = H * V;

  logic        system_clk_in = 1'b0;
  logic        rst_n_in;
  logic        arm_in;
  logic        continuous_in;
  logic        frame_done_in;
  logic        data_valid_in;
  logic [15:0] pixel_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        reader_release_in;
  logic        wr_en_out;
  logic [16:0] wr_addr_out;
  logic [15:0] wr_data_out;
  logic        wr_buf_sel_out;
  logic        rd_buf_sel_out;
  logic        frame_ready_out;
  logic        busy_out;
  logic        overrun_out;
  logic        short_frame_out;
  logic        timeout_out;

  int n_vec = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int fr_cnt = 0;
  int ov_cnt = 0;
  int sh_cnt = 0;
  int to_cnt = 0;
  logic [15:0] mem [0:1023];

  frame_capture_ctrl #(
    .H_ACTIVE       (H),
    .V_ACTIVE       (V),
    .ADDR_W         (17),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .system_clk_in     (system_clk_in),
    .rst_n_in          (rst_n_in),
    .arm_in            (arm_in),
    .continuous_in     (continuous_in),
    .frame_done_in     (frame_done_in),
    .data_valid_in     (data_valid_in),
    .pixel_in          (pixel_in),
    .hcount_in         (hcount_in),
    .vcount_in         (vcount_in),
    .reader_release_in (reader_release_in),
    .wr_en_out         (wr_en_out),
    .wr_addr_out       (wr_addr_out),
    .wr_data_out       (wr_data_out),
    .wr_buf_sel_out    (wr_buf_sel_out),
    .rd_buf_sel_out    (rd_buf_sel_out),
    .frame_ready_out   (frame_ready_out),
    .busy_out          (busy_out),
    .overrun_out       (overrun_out),
    .short_frame_out   (short_frame_out),
    .timeout_out       (timeout_out)
  );

  always #8 system_clk_in = ~system_clk_in;

  always @(negedge system_clk_in) begin
    if (wr_en_out) begin
      wr_cnt++;
      if (int'(wr_addr_out) < 1024) mem[int'(wr_addr_out)] = wr_data_out;
    end
    if (frame_ready_out) fr_cnt++;
    if (overrun_out)     ov_cnt++;
    if (short_frame_out) sh_cnt++;
    if (timeout_out)     to_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] pix_val(input int h, input int v, input int seed);
    return 16'((v * 331 + h * 7 + seed * 4099) & 32'hffff);
  endfunction

  task automatic tick();
    @(posedge system_clk_in);
    #1;
  endtask

  task automatic pulse_arm();
    arm_in = 1'b1;
    tick();
    arm_in = 1'b0;
  endtask

  task automatic pulse_release();
    reader_release_in = 1'b1;
    tick();
    reader_release_in = 1'b0;
  endtask

  // Frame boundary, optionally with a coincident release and/or pixel.
  task automatic pulse_fd(input logic rel, input logic dv);
    frame_done_in     = 1'b1;
    reader_release_in = rel;
    data_valid_in     = dv;
    hcount_in         = 11'd10;
    vcount_in         = 10'd1;
    pixel_in          = 16'hbeef;
    tick();
    frame_done_in     = 1'b0;
    reader_release_in = 1'b0;
    data_valid_in     = 1'b0;
  endtask

  task automatic drive_frame(input int start, input int n, input int seed, input bit chk);
    for (int i = start; i < start + n; i++) begin
      data_valid_in = 1'b1;
      hcount_in     = 11'(i % H);
      vcount_in     = 10'(i / H);
      pixel_in      = pix_val(i % H, i / H, seed);
      tick();
      if (chk && i == 0) begin
        check_eq("first_wr_en", 32'(wr_en_out), 1);
        check_eq("first_addr", 32'(wr_addr_out), 0);
        check_eq("first_data", 32'(wr_data_out), 32'(pix_val(0, 0, seed)));
      end
      if (chk && i == 645) begin
        check_eq("addr_h5_v2", 32'(wr_addr_out), 645);
        check_eq("data_h5_v2", 32'(wr_data_out), 32'(pix_val(5, 2, seed)));
      end
    end
    data_valid_in = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_wr_en"}, 32'(wr_en_out), 0);
    check_eq({tag, "_addr"}, 32'(wr_addr_out), 0);
    check_eq({tag, "_data"}, 32'(wr_data_out), 0);
    check_eq({tag, "_wsel"}, 32'(wr_buf_sel_out), 0);
    check_eq({tag, "_rsel"}, 32'(rd_buf_sel_out), 1);
    check_eq({tag, "_busy"}, 32'(busy_out), 0);
    check_eq({tag, "_status"},
             32'({frame_ready_out, overrun_out, short_frame_out, timeout_out}), 0);
  endtask

  initial begin
    rst_n_in = 1'b0; arm_in = 1'b0; continuous_in = 1'b0; frame_done_in = 1'b0;
    data_valid_in = 1'b0; pixel_in = '0; hcount_in = '0; vcount_in = '0;
    reader_release_in = 1'b0;
    #20;
    check_reset_state("rst");
    tick();
    rst_n_in = 1'b1;
    tick();

    // Short frame: 959 pixels, no swap.
    pulse_arm();
    check_eq("armed_busy", 32'(busy_out), 1);
    pulse_fd(1'b0, 1'b0);
    wr_cnt = 0;
    drive_frame(0, FR - 1, 1, 1'b0);
    tick();
    check_eq("short_wr_cnt", 32'(wr_cnt), FR - 1);
    pulse_fd(1'b0, 1'b0);
    check_eq("short_pulse", 32'(short_frame_out), 1);
    check_eq("short_no_ready", 32'(frame_ready_out), 0);
    check_eq("short_wsel", 32'(wr_buf_sel_out), 0);
    tick();
    check_eq("short_pulse_end", 32'(short_frame_out), 0);
    check_eq("short_idle", 32'(busy_out), 0);

    // Full frame, pixels during ARMED ignored, swap 0 -> 1.
    pulse_arm();
    wr_cnt = 0;
    drive_frame(0, 5, 9, 1'b0);
    tick();
    check_eq("armed_no_wr", 32'(wr_cnt), 0);
    pulse_fd(1'b0, 1'b0);
    drive_frame(0, FR, 2, 1'b1);
    tick();
    check_eq("idle_wr_en", 32'(wr_en_out), 0);
    check_eq("addr_hold", 32'(wr_addr_out), FR - 1);
    check_eq("full_wr_cnt", 32'(wr_cnt), FR);
    check_eq("mem_645", 32'(mem[645]), 32'(pix_val(5, 2, 2)));
    check_eq("mem_last", 32'(mem[FR - 1]), 32'(pix_val(H - 1, V - 1, 2)));
    pulse_fd(1'b0, 1'b0);
    check_eq("full_ready", 32'(frame_ready_out), 1);
    check_eq("full_wsel", 32'(wr_buf_sel_out), 1);
    check_eq("full_rsel", 32'(rd_buf_sel_out), 0);
    check_eq("full_no_short", 32'(short_frame_out), 0);
    tick();
    check_eq("full_ready_end", 32'(frame_ready_out), 0);
    check_eq("full_idle", 32'(busy_out), 0);

    // Reset returns ownership to writer=0.
    rst_n_in = 1'b0;
    #1;
    check_reset_state("rst2");
    tick();
    rst_n_in = 1'b1;
    tick();

    // Continuous: swap, overrun, coincident release+swap, second swap, stop.
    continuous_in = 1'b1;
    tick();
    check_eq("cont_busy", 32'(busy_out), 1);
    pulse_fd(1'b0, 1'b0);
    drive_frame(0, FR, 3, 1'b0);
    pulse_fd(1'b0, 1'b0);
    check_eq("c1_ready", 32'(frame_ready_out), 1);
    check_eq("c1_wsel", 32'(wr_buf_sel_out), 1);
    drive_frame(0, FR, 4, 1'b0);
    pulse_fd(1'b0, 1'b0);
    check_eq("c2_overrun", 32'(overrun_out), 1);
    check_eq("c2_no_ready", 32'(frame_ready_out), 0);
    check_eq("c2_wsel", 32'(wr_buf_sel_out), 1);
    pulse_release();
    drive_frame(0, FR, 5, 1'b0);
    pulse_fd(1'b1, 1'b0);
    check_eq("c3_ready", 32'(frame_ready_out), 1);
    check_eq("c3_wsel", 32'(wr_buf_sel_out), 0);
    drive_frame(0, FR / 2, 6, 1'b0);
    continuous_in = 1'b0;
    drive_frame(FR / 2, FR - FR / 2, 6, 1'b0);
    check_eq("c4_still_busy", 32'(busy_out), 1);
    pulse_fd(1'b0, 1'b0);
    check_eq("c4_ready", 32'(frame_ready_out), 1);
    check_eq("c4_wsel", 32'(wr_buf_sel_out), 1);
    check_eq("c4_idle", 32'(busy_out), 0);

    // Out-of-range coordinates and saturation.
    pulse_release();
    pulse_arm();
    pulse_fd(1'b0, 1'b0);
    wr_cnt = 0;
    data_valid_in = 1'b1; hcount_in = 11'd320; vcount_in = 10'd0; pixel_in = 16'h1111;
    tick();
    check_eq("oor_h320", 32'(wr_en_out), 0);
    hcount_in = 11'd0; vcount_in = 10'd240;
    tick();
    check_eq("oor_v240", 32'(wr_en_out), 0);
    hcount_in = 11'd5; vcount_in = 10'(V);
    tick();
    check_eq("oor_vmax", 32'(wr_en_out), 0);
    drive_frame(0, FR, 7, 1'b0);
    drive_frame(FR - 1, 1, 7, 1'b0);
    tick();
    check_eq("oor_wr_cnt", 32'(wr_cnt), FR + 1);
    pulse_fd(1'b0, 1'b0);
    check_eq("oor_ready", 32'(frame_ready_out), 1);
    check_eq("oor_no_short", 32'(short_frame_out), 0);
    check_eq("oor_wsel", 32'(wr_buf_sel_out), 0);

    // frame_done coincident with a pixel: pixel dropped.
    pulse_arm();
    pulse_fd(1'b0, 1'b0);
    wr_cnt = 0;
    drive_frame(0, 3, 8, 1'b0);
    pulse_fd(1'b0, 1'b1);
    check_eq("fd_dv_no_wr", 32'(wr_en_out), 0);
    check_eq("fd_dv_short", 32'(short_frame_out), 1);
    tick();
    check_eq("fd_dv_wr_cnt", 32'(wr_cnt), 3);

    // Asynchronous reset mid-capture while the writer owns buffer 1.
    pulse_release();
    pulse_arm();
    pulse_fd(1'b0, 1'b0);
    drive_frame(0, FR, 9, 1'b0);
    pulse_fd(1'b0, 1'b0);
    check_eq("pre_rst_wsel", 32'(wr_buf_sel_out), 1);
    pulse_arm();
    pulse_fd(1'b0, 1'b0);
    drive_frame(0, 500, 10, 1'b0);
    check_eq("pre_rst_wr_en", 32'(wr_en_out), 1);
    #2;
    rst_n_in = 1'b0;
    #1;
    check_reset_state("rst_mid");
    tick();
    rst_n_in = 1'b1;
    tick();

`ifdef CAPTURE_TIMEOUT_EN
    begin
      int n;
      n = 0;
      pulse_arm();
      while (timeout_out !== 1'b1 && n < 200) begin
        tick();
        n++;
      end
      check_eq("timeout_cycle", 32'(n), 100);
      check_eq("timeout_idle", 32'(busy_out), 0);
      tick();
      check_eq("timeout_pulse_end", 32'(timeout_out), 0);
    end
    check_eq("timeout_total", 32'(to_cnt), 1);
`else
    check_eq("timeout_total", 32'(to_cnt), 0);
`endif

    check_eq("ready_total", 32'(fr_cnt), 6);
    check_eq("overrun_total", 32'(ov_cnt), 1);
    check_eq("short_total", 32'(sh_cnt), 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
